// File: rtl/pwam_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwam_seq_ctrl_if
// Bundles the signals between the PWAM sequencer and its surroundings: the
// CPU-side command/data path, the operand BRAM banks, the PWAM core and the
// result data memory.
//
// Modports
//   master : the surroundings (drives cmd_go, load_valid, core_done)
//   slave  : the sequencer     (drives everything else)
//
// Handshake rules
//   Operand load: an operand word moves on a rising clock edge where
//   load_valid && load_ready. load_ready is high only in LOAD. load_valid
//   may be raised or dropped on any cycle; dropping it stalls the load with
//   no write and no address advance. The word is written to
//   bank bram_we (one-hot) at bram_addr in the same cycle.
//   cmd_go is a level that is only looked at while cmd_busy is low.
//   core_done is only looked at while the sequencer waits on the core;
//   it may be a pulse or a level.
// ---------------------------------------------------------------------------
interface pwam_seq_ctrl_if #(
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 7
);
    logic               cmd_go;
    logic               cmd_busy;
    logic               load_valid;
    logic               load_ready;
    logic [NUM_OPS-1:0] bram_we;
    logic [CNT_W-1:0]   bram_addr;
    logic [1:0]         addr_sel;
    logic               core_start;
    logic               core_done;
    logic               dmem_we;
    logic [CNT_W-1:0]   dmem_addr;
    logic               done_pulse;
    logic               err_timeout;

    modport master (
        output cmd_go, load_valid, core_done,
        input  cmd_busy, load_ready, bram_we, bram_addr, addr_sel,
               core_start, dmem_we, dmem_addr, done_pulse, err_timeout
    );

    modport slave (
        input  cmd_go, load_valid, core_done,
        output cmd_busy, load_ready, bram_we, bram_addr, addr_sel,
               core_start, dmem_we, dmem_addr, done_pulse, err_timeout
    );
endinterface

// File: rtl/pwam_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pwam_seq_ctrl
// Command sequencer for the point-wise multiply (PWAM) accelerator. One
// command loads NUM_OPS operand polynomials of N_COEF coefficients into the
// operand BRAM banks, pulses the core start, waits for core completion
// (bounded by TIMEOUT cycles), drains N_COEF results to data memory and
// finishes with a one-cycle done pulse.
//
// Ports
//   CLK        : clock, rising edge
//   RST        : asynchronous reset, active low
//   bus        : pwam_seq_ctrl_if.slave (command, load handshake, BRAM,
//                core and data-memory signals)
//   dbg_state  : current FSM state encoding, for observation only
//   cyc_count  : busy-cycle counter, present only when PWAM_PERF_CNT_EN
//                is defined
//
// Optional feature macro: PWAM_PERF_CNT_EN
// ---------------------------------------------------------------------------
module pwam_seq_ctrl #(
    parameter int N_COEF  = 128,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64,
    parameter int TMO_W   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    pwam_seq_ctrl_if.slave       bus,
    output logic [2:0]           dbg_state
`ifdef PWAM_PERF_CNT_EN
    ,
    output logic [31:0]          cyc_count
`endif
);

    localparam int                OP_W     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_COEF - 1);
    localparam logic [OP_W-1:0]   LAST_OP  = OP_W'(NUM_OPS - 1);
    localparam logic [TMO_W-1:0]  LAST_TMO = TMO_W'(TIMEOUT - 1);
    localparam bit                TMO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    op_idx_q, op_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;
    logic               dmem_we_q, dmem_we_d;
    logic [CNT_W-1:0]   dmem_addr_q, dmem_addr_d;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            op_idx_q    <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            op_idx_q    <= op_idx_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            dmem_we_q   <= dmem_we_d;
            dmem_addr_q <= dmem_addr_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        op_idx_d = op_idx_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        err_d    = err_q;
        // BRAM read data arrives one cycle after the DRAIN address, so the
        // data-memory write is the DRAIN read delayed by one register stage.
        dmem_we_d   = (state_q == S_DRAIN);
        dmem_addr_d = (state_q == S_DRAIN) ? cnt_q : '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_go) begin
                    state_d  = S_LOAD;
                    op_idx_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (op_idx_q == LAST_OP) begin
                            state_d = S_START;
                        end else begin
                            op_idx_d = op_idx_q + OP_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (bus.core_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                    if (TMO_EN && (timer_q == LAST_TMO)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.cmd_busy   = (state_q != S_IDLE);
        bus.load_ready = 1'b0;
        bus.bram_we    = '0;
        bus.bram_addr  = '0;
        bus.addr_sel   = 2'd0;
        bus.core_start = 1'b0;
        bus.done_pulse = 1'b0;

        case (state_q)
            S_LOAD: begin
                bus.load_ready = 1'b1;
                bus.addr_sel   = 2'd1;
                bus.bram_addr  = cnt_q;
                if (bus.load_valid) begin
                    bus.bram_we = NUM_OPS'(1) << op_idx_q;
                end
            end
            S_START: begin
                bus.core_start = 1'b1;
                bus.addr_sel   = 2'd2;
            end
            S_WAIT: begin
                bus.addr_sel = 2'd2;
            end
            S_DRAIN: begin
                bus.addr_sel  = 2'd3;
                bus.bram_addr = cnt_q;
            end
            S_FLUSH: begin
                // Last data-memory write is still in flight on the drain path.
                bus.addr_sel = 2'd3;
            end
            S_DONE: begin
                bus.done_pulse = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.dmem_we     = dmem_we_q;
    assign bus.dmem_addr   = dmem_addr_q;
    assign bus.err_timeout = err_q;
    assign dbg_state       = state_q;

`ifdef PWAM_PERF_CNT_EN
    logic [31:0] cyc_count_q, cyc_count_d;

    always_comb begin
        cyc_count_d = cyc_count_q;
        if ((state_q == S_IDLE) && bus.cmd_go) begin
            cyc_count_d = '0;
        end else if ((state_q != S_IDLE) && (cyc_count_q != 32'hFFFF_FFFF)) begin
            cyc_count_d = cyc_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cyc_count_q <= '0;
        end else begin
            cyc_count_q <= cyc_count_d;
        end
    end

    assign cyc_count = cyc_count_q;
`endif

endmodule

// File: tb/tb_pwam_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwam_seq_ctrl
// Self-checking bench for pwam_seq_ctrl. Instance u_a uses the default
// geometry (128 coefficients, 2 operands, timeout 64); instance u_b uses
// 16 coefficients and 3 operands with core_done held high. Observed events
// are collected into a queue and compared with a queue built from the
// command-level rules (what must be written, where, and in which order).
// ---------------------------------------------------------------------------
module tb_pwam_seq_ctrl;

    localparam int N     = 128;
    localparam int OPS   = 2;
    localparam int CW    = 7;
    localparam int TMO   = 64;
    localparam int N_B   = 16;
    localparam int OPS_B = 3;
    localparam int CW_B  = 4;
    localparam int MAX_IT = 4000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pwam_seq_ctrl_if #(.NUM_OPS(OPS),   .CNT_W(CW))   a_if ();
    pwam_seq_ctrl_if #(.NUM_OPS(OPS_B), .CNT_W(CW_B)) b_if ();
    logic [2:0] a_dbg, b_dbg;
`ifdef PWAM_PERF_CNT_EN
    logic [31:0] a_cyc, b_cyc;
`endif

    pwam_seq_ctrl #(.N_COEF(N), .NUM_OPS(OPS), .CNT_W(CW), .TIMEOUT(TMO), .TMO_W(8)) u_a (
        .CLK(clk), .RST(rst_n), .bus(a_if), .dbg_state(a_dbg)
`ifdef PWAM_PERF_CNT_EN
        , .cyc_count(a_cyc)
`endif
    );

    pwam_seq_ctrl #(.N_COEF(N_B), .NUM_OPS(OPS_B), .CNT_W(CW_B), .TIMEOUT(TMO), .TMO_W(8)) u_b (
        .CLK(clk), .RST(rst_n), .bus(b_if), .dbg_state(b_dbg)
`ifdef PWAM_PERF_CNT_EN
        , .cyc_count(b_cyc)
`endif
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event encoding: [15:12] kind, [11:8] bank, [7:0] address.
    // kind 1 bram write, 2 core_start, 3 dmem write, 4 done_pulse,
    // 5 timeout flag rising, 7 bram_we not one-hot.
    function automatic logic [15:0] ev(input int t, input int b, input int a);
        return {t[3:0], b[3:0], a[7:0]};
    endfunction

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    bit          lv_hist[0:MAX_IT-1];
    int          start_cyc, pulse_cyc, err_cyc, cdone_cyc;
    logic        prev_err;
    logic        err_at1;

    typedef struct {
        int lv_mode;     // 0 held high, 1 toggled, 2 random
        int done_dly;    // cycles from core_start to core_done, -1 never
        bit go_in_drain;
        bit done_in_load;
        int exp_start;   // cmd_go -> core_start, -1 derive from load_valid history
        int exp_fin;     // core_done -> done_pulse, or core_start -> timeout flag
        bit exp_err;
    } vec_t;

    // ---------------- monitor for instance A ----------------
    task automatic sample_a(input int it);
        if (a_if.bram_we != '0) begin
            int b;
            b = 0;
            for (int k = 0; k < OPS; k++) if (a_if.bram_we[k]) b = k;
            if (!$onehot(a_if.bram_we)) obs_q.push_back(ev(7, 0, 0));
            obs_q.push_back(ev(1, b, int'(a_if.bram_addr)));
        end
        if (a_if.core_start) begin
            obs_q.push_back(ev(2, 0, 0));
            if (start_cyc < 0) start_cyc = it;
        end
        if (a_if.dmem_we) obs_q.push_back(ev(3, 0, int'(a_if.dmem_addr)));
        if (a_if.done_pulse) begin
            obs_q.push_back(ev(4, 0, 0));
            pulse_cyc = it;
        end
        if (a_if.err_timeout && !prev_err) begin
            obs_q.push_back(ev(5, 0, 0));
            err_cyc = it;
        end
        prev_err = a_if.err_timeout;
    endtask

    // ---------------- driver + scoreboard for one command on A ----------------
    task automatic run_and_check(input vec_t v, input string tag);
        int  stop;
        int  exp_start;
        int  acc;
        int  fin;
        int  diff;
        bit  lv;
        bit  cd;
        obs_q.delete();
        exp_q.delete();
        start_cyc = -1; pulse_cyc = -1; err_cyc = -1; cdone_cyc = -1;
        prev_err  = a_if.err_timeout;
        err_at1   = 1'bx;
        stop      = -1;
        for (int it = 0; it < MAX_IT; it++) begin
            @(posedge clk);
            #1;
            a_if.cmd_go = (it == 0) || (v.go_in_drain && cdone_cyc >= 0 && it == cdone_cyc + 5);
            case (v.lv_mode)
                0:       lv = 1'b1;
                1:       lv = (it % 2) == 1;
                default: lv = 1'($urandom_range(0, 1));
            endcase
            lv_hist[it]     = lv;
            a_if.load_valid = lv;
            cd = v.done_in_load && it >= 5 && it <= 8;
            if (v.done_dly >= 0 && start_cyc >= 0 && it == start_cyc + v.done_dly) begin
                cd        = 1'b1;
                cdone_cyc = it;
            end
            a_if.core_done = cd;
            @(negedge clk);
            if (it == 1) err_at1 = a_if.err_timeout;
            sample_a(it);
            if (stop < 0 && (pulse_cyc >= 0 || err_cyc >= 0)) stop = it + 3;
            if (it == stop) break;
        end
        a_if.cmd_go     = 1'b0;
        a_if.load_valid = 1'b0;
        a_if.core_done  = 1'b0;

        // Reference: every operand word in bank/address order, one start,
        // then either all results in order plus done, or the timeout flag.
        for (int op = 0; op < OPS; op++)
            for (int a = 0; a < N; a++) exp_q.push_back(ev(1, op, a));
        exp_q.push_back(ev(2, 0, 0));
        if (!v.exp_err) begin
            for (int a = 0; a < N; a++) exp_q.push_back(ev(3, 0, a));
            exp_q.push_back(ev(4, 0, 0));
        end else begin
            exp_q.push_back(ev(5, 0, 0));
        end

        // Start latency from the load_valid history: one cycle after the
        // cycle that supplied the last operand word.
        exp_start = v.exp_start;
        if (exp_start < 0) begin
            acc = 0;
            for (int it = 1; it < MAX_IT; it++) begin
                if (lv_hist[it]) acc++;
                if (acc == OPS * N) begin
                    exp_start = it + 1;
                    break;
                end
            end
        end

        fin = v.exp_err ? (err_cyc - start_cyc) : (pulse_cyc - cdone_cyc);
        diff = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                diff = i;
                break;
            end
        end

        check({tag, "_finished"},      stop >= 0, 1);
        check({tag, "_err_clear_go"},  err_at1, 0);
        check({tag, "_start_lat"},     start_cyc, exp_start);
        check({tag, "_finish_lat"},    fin, v.exp_fin);
        check({tag, "_err_flag"},      a_if.err_timeout, v.exp_err);
        check({tag, "_busy_after"},    a_if.cmd_busy, 0);
        check({tag, "_evt_count"},     obs_q.size(), exp_q.size());
        check({tag, "_evt_first_diff"}, diff, -1);
    endtask

    task automatic check_a_quiet(input string tag);
        check({tag, "_busy"},      a_if.cmd_busy, 0);
        check({tag, "_load_rdy"},  a_if.load_ready, 0);
        check({tag, "_bram"},      {a_if.bram_we, a_if.bram_addr, a_if.addr_sel}, 0);
        check({tag, "_start"},     a_if.core_start, 0);
        check({tag, "_dmem"},      {a_if.dmem_we, a_if.dmem_addr}, 0);
        check({tag, "_done_err"},  {a_if.done_pulse, a_if.err_timeout}, 0);
        check({tag, "_state"},     a_dbg, 0);
`ifdef PWAM_PERF_CNT_EN
        check({tag, "_cyc_count"}, a_cyc, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl[7];

    initial begin
        vec_t rv;
        int   nbw, bad_bw, nd, bad_d, st_b, pl_b;
        logic [31:0] cyc_b;

        tbl[0] = '{0, 10, 1'b0, 1'b0, 257, N + 2, 1'b0};   // basic command
        tbl[1] = '{1, 10, 1'b0, 1'b0, 512, N + 2, 1'b0};   // load_valid toggling
        tbl[2] = '{0, -1, 1'b0, 1'b0, 257, TMO + 1, 1'b1}; // core never done
        tbl[3] = '{0, 10, 1'b0, 1'b0, 257, N + 2, 1'b0};   // new command clears flag
        tbl[4] = '{0, 10, 1'b1, 1'b1, 257, N + 2, 1'b0};   // stray cmd_go / core_done
        tbl[5] = '{0, 64, 1'b0, 1'b0, 257, N + 2, 1'b0};   // done on last WAIT cycle wins
        tbl[6] = '{0, 65, 1'b0, 1'b0, 257, TMO + 1, 1'b1}; // one cycle too late

        a_if.cmd_go = 1'b0; a_if.load_valid = 1'b0; a_if.core_done = 1'b0;
        b_if.cmd_go = 1'b0; b_if.load_valid = 1'b0; b_if.core_done = 1'b0;

        #2 rst_n = 1'b0;
        #10;
        check_a_quiet("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_and_check(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rv.lv_mode      = 2;
            rv.done_dly     = int'($urandom_range(1, 80));
            rv.go_in_drain  = 1'($urandom_range(0, 1));
            rv.done_in_load = 1'($urandom_range(0, 1));
            rv.exp_start    = -1;
            rv.exp_err      = rv.done_dly > TMO;
            rv.exp_fin      = rv.exp_err ? TMO + 1 : N + 2;
            run_and_check(rv, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of loading operand 1, word 70.
        for (int it = 0; it < 200; it++) begin
            @(posedge clk);
            #1;
            a_if.cmd_go     = (it == 0);
            a_if.load_valid = 1'b1;
            a_if.core_done  = 1'b0;
            @(negedge clk);
            if (it == 199) begin
                check("midrst_pre_bank", a_if.bram_we, 2'b10);
                check("midrst_pre_addr", a_if.bram_addr, 70);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check_a_quiet("midrst");
        a_if.load_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_and_check(tbl[0], "after_rst");

        // Instance B: 16 coefficients, 3 operands, core_done held high.
        nbw = 0; bad_bw = 0; nd = 0; bad_d = 0; st_b = -1; pl_b = -1; cyc_b = '1;
        for (int it = 0; it < 200; it++) begin
            @(posedge clk);
            #1;
            b_if.cmd_go     = (it == 0);
            b_if.load_valid = 1'b1;
            b_if.core_done  = 1'b1;
            @(negedge clk);
            if (b_if.bram_we != '0) begin
                if (b_if.bram_we !== 3'(1 << (nbw / N_B)) || int'(b_if.bram_addr) != nbw % N_B)
                    bad_bw++;
                nbw++;
            end
            if (b_if.core_start && st_b < 0) st_b = it;
            if (b_if.dmem_we) begin
                if (int'(b_if.dmem_addr) != nd) bad_d++;
                nd++;
            end
            if (b_if.done_pulse) pl_b = it;
`ifdef PWAM_PERF_CNT_EN
            if (pl_b >= 0 && it == pl_b + 1) cyc_b = b_cyc;
`endif
            if (pl_b >= 0 && it == pl_b + 3) break;
        end
        b_if.cmd_go = 1'b0; b_if.load_valid = 1'b0; b_if.core_done = 1'b0;
        check("b_bram_writes",   nbw, OPS_B * N_B);
        check("b_bram_order",    bad_bw, 0);
        check("b_dmem_writes",   nd, N_B);
        check("b_dmem_order",    bad_d, 0);
        check("b_start_lat",     st_b, OPS_B * N_B + 1);
        check("b_done_lat",      pl_b, OPS_B * N_B + 1 + 1 + N_B + 2);
`ifdef PWAM_PERF_CNT_EN
        check("b_cyc_count",     cyc_b, 68);
        check("b_cyc_hold",      b_cyc, 68);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
